// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the instruction-memory handshake and the decode-side
//             instruction/redirect signals of the fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
   localparam int W_CPU    = 32;
   localparam int W_PC_SRC = 2;
   localparam int W_JADDR  = 26;
   localparam int W_IMM    = 16;

   // instruction memory side
   logic                imem_req;
   logic [W_CPU-1:0]    imem_addr;
   logic                imem_ack;
   logic [W_CPU-1:0]    imem_rdata;

   // decode side
   logic [W_CPU-1:0]    inst;
   logic [W_CPU-1:0]    inst_pc;
   logic                inst_valid;
   logic                inst_ready;
   logic                redirect;
   logic [W_PC_SRC-1:0] pc_src;
   logic [W_JADDR-1:0]  jump_addr;
   logic [W_IMM-1:0]    imm;
   logic [W_CPU-1:0]    reg_addr;

   // fetch unit view
   modport master (
      output imem_req, imem_addr, inst, inst_pc, inst_valid,
      input  imem_ack, imem_rdata, inst_ready, redirect, pc_src,
             jump_addr, imm, reg_addr
   );

   // memory / decode view
   modport slave (
      input  imem_req, imem_addr, inst, inst_pc, inst_valid,
      output imem_ack, imem_rdata, inst_ready, redirect, pc_src,
             jump_addr, imm, reg_addr
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : MIPS instruction fetch stage. Requests words from instruction
//             memory over req/ack, buffers them with their PC in a 2-entry
//             FIFO for decode, and applies jump/branch/register redirects.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   localparam logic [1:0] PC_SRC_NEXT = 2'd0;
   localparam logic [1:0] PC_SRC_JUMP = 2'd1;
   localparam logic [1:0] PC_SRC_BRCH = 2'd2;
   localparam logic [1:0] PC_SRC_REGF = 2'd3;
   localparam logic [1:0] FIFO_DEPTH  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_fpc;
   logic [31:0] r_req_addr;
   logic [31:0] r_mem_inst [0:1];
   logic [31:0] r_mem_pc   [0:1];
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_count;

   logic        w_req;
   logic [31:0] w_addr;
   logic        w_valid;
   logic        w_pop;
   logic        w_redir;
   logic        w_ack;
   logic        w_push;
   logic [31:0] w_pc4;
   logic [31:0] w_br_off;
   logic [31:0] w_target;

   // Request is derived purely from state, so it never drops before its ack:
   // the count only grows on an ack.
   assign w_req   = ((r_state == ST_FETCH) && (r_count != FIFO_DEPTH)) ||
                    (r_state == ST_DROP);
   assign w_addr  = (r_state == ST_DROP) ? r_req_addr : r_fpc;
   assign w_valid = (r_count != 2'd0);
   assign w_pop   = w_valid & bus.inst_ready;
   assign w_redir = w_pop & bus.redirect & (bus.pc_src != PC_SRC_NEXT);
   assign w_ack   = w_req & bus.imem_ack;
   // A response that lands together with a redirect belongs to the old path.
   assign w_push  = (r_state == ST_FETCH) & w_ack & ~w_redir;

   assign w_pc4    = r_mem_pc[r_rd_ptr] + 32'd4;
   assign w_br_off = {{14{bus.imm[15]}}, bus.imm, 2'b00};

   // Redirect target selection for the instruction being popped
   always_comb begin
      w_target = bus.reg_addr;
      case (bus.pc_src)
         PC_SRC_JUMP: w_target = {w_pc4[31:28], bus.jump_addr, 2'b00};
         PC_SRC_BRCH: w_target = w_pc4 + w_br_off;
         PC_SRC_REGF: w_target = bus.reg_addr;
         default:     w_target = bus.reg_addr;
      endcase
   end

   // Fetch FSM: tracks the fetch PC and whether a stale request must be drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_fpc      <= RESET_PC;
         r_req_addr <= RESET_PC;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (w_redir) begin
                  r_fpc <= w_target;
                  // The memory still owes a word for the old address; wait it out.
                  if (w_req && !bus.imem_ack) begin
                     r_req_addr <= w_addr;
                     r_state    <= ST_DROP;
                  end
               end else if (w_ack) begin
                  r_fpc <= r_fpc + 32'd4;
               end
            end
            ST_DROP: begin
               if (bus.imem_ack)
                  r_state <= ST_FETCH;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Two-entry instruction FIFO; a redirect flushes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_inst[0] <= '0;
         r_mem_inst[1] <= '0;
         r_mem_pc[0]   <= '0;
         r_mem_pc[1]   <= '0;
         r_rd_ptr      <= 1'b0;
         r_wr_ptr      <= 1'b0;
         r_count       <= 2'd0;
      end else if (w_redir) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem_inst[r_wr_ptr] <= bus.imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_fpc;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = w_addr;
   assign bus.inst_valid = w_valid;
   assign bus.inst       = r_mem_inst[r_rd_ptr];
   assign bus.inst_pc    = r_mem_pc[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit: directed scenarios plus a
//             randomized run scored against an architectural PC-stream model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
   localparam logic [31:0] K    = 32'hA5A5_0000;
   localparam logic [1:0]  NEXT = 2'd0;
   localparam logic [1:0]  JUMP = 2'd1;
   localparam logic [1:0]  BRCH = 2'd2;
   localparam logic [1:0]  REGF = 2'd3;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   lat;
   int   wait_cnt;

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instruction memory: acks after 'lat' waiting cycles, data = addr ^ K
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          wait_cnt <= 0;
      else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
      else                                 wait_cnt <= 0;
   end

   always @* begin
      bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
      bus.imem_rdata = bus.imem_addr ^ K;
   end

   task automatic clear_inputs();
      bus.inst_ready = 1'b0;
      bus.redirect   = 1'b0;
      bus.pc_src     = NEXT;
      bus.jump_addr  = '0;
      bus.imm        = '0;
      bus.reg_addr   = '0;
   endtask

   // entered and left on a falling edge; releases reset on a falling edge
   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // pops the head with a redirect over one rising edge
   task automatic drive_redirect(input logic [1:0] src, input logic [25:0] ja,
                                 input logic [15:0] im, input logic [31:0] ra);
      bus.inst_ready = 1'b1;
      bus.redirect   = 1'b1;
      bus.pc_src     = src;
      bus.jump_addr  = ja;
      bus.imm        = im;
      bus.reg_addr   = ra;
      @(negedge clk);
      bus.redirect   = 1'b0;
      bus.pc_src     = NEXT;
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
      vectors++; if (bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr); end
      vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
      vectors++; if (bus.inst !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h expected 00000000", bus.inst); end
      vectors++; if (bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc: got %h expected 00000000", bus.inst_pc); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      bus.inst_ready = 1'b1;
      @(negedge clk);
      vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL stream_early_valid: got %b expected 0", bus.inst_valid); end
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr); end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i) || bus.inst !== (32'(4*i) ^ K)) begin
            miscompares++;
            $display("FAIL stream_seq[%0d]: got valid=%b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                     i, bus.inst_valid, bus.inst_pc, bus.inst, 32'(4*i), 32'(4*i) ^ K);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      lat = 0;
      apply_reset();
      repeat (5) @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_drop: got %b expected 0", bus.imem_req); end
      vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000000", bus.inst_valid, bus.inst_pc); end
      bus.inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4*i) || bus.inst !== (32'(4*i) ^ K)) begin
            miscompares++;
            $display("FAIL bp_drain[%0d]: got valid=%b pc=%h inst=%h expected valid=1 pc=%h",
                     i, bus.inst_valid, bus.inst_pc, bus.inst, 32'(4*i));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_jump();
      lat = 0;
      apply_reset();
      bus.inst_ready = 1'b1;
      repeat (2) @(negedge clk);
      drive_redirect(REGF, '0, '0, 32'h0040_0010);
      @(negedge clk);
      vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0040_0010) begin miscompares++; $display("FAIL jump_setup: got valid=%b pc=%h expected valid=1 pc=00400010", bus.inst_valid, bus.inst_pc); end
      drive_redirect(JUMP, 26'h000_0100, '0, '0);
      vectors++; if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL jump_flush: got valid=%b expected 0", bus.inst_valid); end
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0400) begin miscompares++; $display("FAIL jump_req: got req=%b addr=%h expected req=1 addr=00000400", bus.imem_req, bus.imem_addr); end
      @(negedge clk);
      vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0400 || bus.inst !== (32'h400 ^ K)) begin miscompares++; $display("FAIL jump_target: got valid=%b pc=%h inst=%h expected valid=1 pc=00000400", bus.inst_valid, bus.inst_pc, bus.inst); end
   endtask

   task automatic test_branch_wrap();
      drive_redirect(REGF, '0, '0, 32'h0000_0008);
      @(negedge clk);
      vectors++; if (bus.inst_pc !== 32'h0000_0008) begin miscompares++; $display("FAIL br_setup1: got pc=%h expected 00000008", bus.inst_pc); end
      drive_redirect(BRCH, '0, 16'hFFFC, '0);
      vectors++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL br_back_addr: got %h expected fffffffc", bus.imem_addr); end
      @(negedge clk);
      vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL br_back_pc: got valid=%b pc=%h expected valid=1 pc=fffffffc", bus.inst_valid, bus.inst_pc); end
      drive_redirect(REGF, '0, '0, 32'hFFFF_FFF8);
      @(negedge clk);
      drive_redirect(BRCH, '0, 16'h0001, '0);
      vectors++; if (bus.imem_addr !== 32'h0000_0000) begin miscompares++; $display("FAIL br_wrap_addr: got %h expected 00000000", bus.imem_addr); end
      @(negedge clk);
      vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0000_0000 || bus.inst !== K) begin miscompares++; $display("FAIL br_wrap_pc: got valid=%b pc=%h expected valid=1 pc=00000000", bus.inst_valid, bus.inst_pc); end
   endtask

   // leaves the DUT with head pc 0x4 and a pending request to 0x8
   task automatic enter_drop_setup();
      lat = 3;
      apply_reset();
      for (int i = 0; i < 40 && !(bus.inst_valid && !bus.imem_req); i++) @(negedge clk);
      bus.inst_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_drop();
      bit seen;
      enter_drop_setup();
      vectors++; if (bus.inst_pc !== 32'h4 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8 || bus.imem_ack !== 1'b0) begin miscompares++; $display("FAIL drop_setup: got pc=%h req=%b addr=%h ack=%b expected pc=4 req=1 addr=8 ack=0", bus.inst_pc, bus.imem_req, bus.imem_addr, bus.imem_ack); end
      drive_redirect(REGF, '0, '0, 32'h0000_1000);
      for (int i = 0; i < 10 && !bus.imem_ack; i++) begin
         vectors++; if (bus.imem_addr !== 32'h8 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL drop_hold: got req=%b addr=%h valid=%b expected req=1 addr=8 valid=0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
         @(negedge clk);
      end
      vectors++; if (bus.imem_ack !== 1'b1 || bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL drop_ack: got ack=%b addr=%h expected ack=1 addr=8", bus.imem_ack, bus.imem_addr); end
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000 || bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL drop_refetch: got req=%b addr=%h valid=%b expected req=1 addr=00001000 valid=0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = bus.inst_valid;
      end
      vectors++; if (!seen || bus.inst_pc !== 32'h1000 || bus.inst !== (32'h1000 ^ K)) begin miscompares++; $display("FAIL drop_first_valid: got valid=%b pc=%h inst=%h expected valid=1 pc=00001000", seen, bus.inst_pc, bus.inst); end
   endtask

   task automatic test_async_reset();
      enter_drop_setup();
      drive_redirect(REGF, '0, '0, 32'h0000_1000);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin miscompares++; $display("FAIL ar_in_drop: got req=%b addr=%h expected req=1 addr=8", bus.imem_req, bus.imem_addr); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL ar_immediate: got req=%b valid=%b addr=%h expected req=0 valid=0 addr=0", bus.imem_req, bus.inst_valid, bus.imem_addr); end
      clear_inputs();
      lat = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL ar_restart_req: got req=%b addr=%h valid=%b expected req=1 addr=0 valid=0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
      @(negedge clk);
      vectors++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== K) begin miscompares++; $display("FAIL ar_restart_head: got valid=%b pc=%h inst=%h expected valid=1 pc=0", bus.inst_valid, bus.inst_pc, bus.inst); end
   endtask

   // random ready/redirect traffic, scored against the program-order PC stream
   task automatic test_random();
      for (int run = 0; run < 3; run++) begin
         logic [31:0] exp_pc;
         logic        rdy;
         logic        rd;
         logic [1:0]  src;
         logic [25:0] ja;
         logic [15:0] im;
         logic [31:0] ra;
         int          pops;
         int          br_off;
         lat = $urandom_range(0, 3);
         apply_reset();
         exp_pc = 32'h0;
         pops   = 0;
         for (int cyc = 0; cyc < 600; cyc++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 4) == 0);
            src = 2'($urandom_range(0, 3));
            ja  = 26'($urandom);
            im  = 16'($urandom);
            ra  = $urandom;
            bus.inst_ready = rdy;
            bus.redirect   = rd;
            bus.pc_src     = src;
            bus.jump_addr  = ja;
            bus.imm        = im;
            bus.reg_addr   = ra;
            if (bus.inst_valid && rdy) begin
               vectors++;
               if (bus.inst_pc !== exp_pc || bus.inst !== (exp_pc ^ K)) begin
                  miscompares++;
                  $display("FAIL rand_pop run=%0d cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                           run, cyc, bus.inst_pc, bus.inst, exp_pc, exp_pc ^ K);
               end
               pops++;
               if (rd && src == JUMP)
                  exp_pc = ((exp_pc + 32'd4) & 32'hF000_0000) | (32'(ja) * 32'd4);
               else if (rd && src == BRCH) begin
                  br_off = int'(signed'(im)) * 4;
                  exp_pc = exp_pc + 32'd4 + 32'(br_off);
               end else if (rd && src == REGF)
                  exp_pc = ra;
               else
                  exp_pc = exp_pc + 32'd4;
            end
            @(negedge clk);
         end
         clear_inputs();
         vectors++; if (pops < 40) begin miscompares++; $display("FAIL rand_progress run=%0d: got %0d pops expected at least 40", run, pops); end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      lat         = 0;
      rst_n       = 1'b0;
      clear_inputs();
      test_reset();
      test_stream();
      test_backpressure();
      test_jump();
      test_branch_wrap();
      test_drop();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
